pc_fetch_ctrl: RTL

//  Fetch-stage controller. Owns PCF, arbitrates the redirect sources (Jalr/Branch from EX, Jal from ID) against sequential PC+4,

---
 rtl/pc_fetch_ctrl_if.sv | 22 ++
 rtl/pc_fetch_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and imem.
// The request side holds imem_req and a stable imem_addr until imem_ack returns the word.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns PCF, arbitrates EX/ID redirects against PC+4,
// runs the imem req/ack handshake and holds a fetched word while decode stalls.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   CPU_CLK,
  input  logic                   CPU_RST,
  input  logic                   StallF,
  input  logic                   BranchE,
  input  logic [31:0]            BranchTarget,
  input  logic                   JalrE,
  input  logic [31:0]            JalrTarget,
  input  logic                   JalD,
  input  logic [31:0]            JalTarget,
  pc_fetch_ctrl_if.master        imem,
  output logic [31:0]            PCF,
  output logic [31:0]            InstrF,
  output logic                   FetchValidF,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   RedirectPend
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] buf_q, buf_d;

  logic        ex_redir;
  logic        redir;
  logic [31:0] raw_tgt;
  logic [31:0] redir_tgt;
  logic        req;
  logic        fetch_valid;
  logic [31:0] instr;

  // Redirect priority: Jalr > Branch > Jal; a Jal beside an EX redirect is wrong-path.
  always_comb begin
    ex_redir = JalrE | BranchE;
    redir    = ex_redir | JalD;
    if (JalrE) begin
      raw_tgt = JalrTarget;
    end else if (BranchE) begin
      raw_tgt = BranchTarget;
    end else begin
      raw_tgt = JalTarget;
    end
    redir_tgt = {raw_tgt[31:2], 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    buf_d       = buf_q;
    req         = 1'b0;
    fetch_valid = 1'b0;
    instr       = buf_q;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          if (redir) begin
            pcf_d  = redir_tgt;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pcf_d  = pend_tgt_q;
            pend_d = 1'b0;
          end else if (!StallF) begin
            fetch_valid = 1'b1;
            instr       = imem.imem_rdata;
            pcf_d       = pcf_q + 32'd4;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redir) begin
          // Address must stay stable until ack, so the redirect waits here.
          pend_d     = 1'b1;
          pend_tgt_d = redir_tgt;
        end
      end
      S_HOLD: begin
        if (redir) begin
          pcf_d   = redir_tgt;
          state_d = S_FETCH;
        end else if (!StallF) begin
          fetch_valid = 1'b1;
          pcf_d       = pcf_q + 32'd4;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q    <= S_FETCH;
      pcf_q      <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
      buf_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      buf_q      <= buf_d;
    end
  end

  assign imem.imem_req  = req & ~CPU_RST;
  assign imem.imem_addr = pcf_q;
  assign PCF            = pcf_q;
  assign InstrF         = CPU_RST ? 32'h0 : instr;
  assign FetchValidF    = fetch_valid & ~CPU_RST;
  assign FlushD         = redir & ~CPU_RST;
  assign FlushE         = ex_redir & ~CPU_RST;
  assign RedirectPend   = pend_q;

endmodule
